// File: rtl/toggle_monitor.sv
`default_nettype none
// ============================================================================
// Module   : toggle_monitor
// Purpose  : Samples an asynchronous toggling/held signal on CLK and classifies
//            it. Reports rise/fall/any-edge pulses, the rising-to-rising period,
//            a running edge count, and a STUCK flag when the signal stops
//            toggling for TIMEOUT cycles.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   CNT_W      width of PERIOD and of the period / idle counters
//   TIMEOUT    consecutive edge-free cycles that declare STUCK (2..2^CNT_W-1)
// Ports:
//   CLK        clock, all state updates on posedge
//   RST_N      synchronous active-low reset
//   DIN        monitored signal, asynchronous to CLK
//   LEVEL      synchronized level of DIN
//   RISE       one-cycle pulse per detected rising edge
//   FALL       one-cycle pulse per detected falling edge
//   EDGE       RISE | FALL
//   PERIOD     last rising-to-rising period in CLK cycles, saturating
//   PERIOD_VLD one-cycle pulse when PERIOD is updated
//   STUCK      high while no edge has been seen for TIMEOUT cycles
//   EDGE_CNT   count of detected edges, wraps modulo 256
// ============================================================================
module toggle_monitor #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             DIN,
    output logic             LEVEL,
    output logic             RISE,
    output logic             FALL,
    output logic             EDGE,
    output logic [CNT_W-1:0] PERIOD,
    output logic             PERIOD_VLD,
    output logic             STUCK,
    output logic [7:0]       EDGE_CNT
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no valid rise reference
        ARMED = 2'd1,   // a rise has been seen, r_pcnt is meaningful
        STK   = 2'd2    // no edge for TIMEOUT cycles
    } state_t;

    state_t           r_state;
    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [CNT_W-1:0] r_pcnt;
    logic [CNT_W-1:0] r_icnt;

    logic             w_rise;
    logic             w_fall;
    logic             w_edge;
    logic [CNT_W-1:0] w_icnt_nxt;
    logic [CNT_W-1:0] w_period_nxt;
    logic             w_timeout;

    // r_s1/r_s2 form the synchronizer; r_s3 holds the previous synchronized
    // level so edges are detected on clean, already-synchronized data.
    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;
    assign w_edge = w_rise | w_fall;

    assign w_icnt_nxt   = (r_icnt == C_TIMEOUT) ? r_icnt : r_icnt + 1'b1;
    // r_pcnt was cleared on the previous rise, so it lags the true period by 1.
    assign w_period_nxt = (r_pcnt == C_CNT_MAX) ? C_CNT_MAX : r_pcnt + 1'b1;
    // An edge this cycle always wins over the timeout.
    assign w_timeout    = ~w_edge & (w_icnt_nxt == C_TIMEOUT);

    assign LEVEL = r_s2;
    assign EDGE  = RISE | FALL;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_s3       <= 1'b0;
            r_pcnt     <= '0;
            r_icnt     <= '0;
            r_state    <= IDLE;
            RISE       <= 1'b0;
            FALL       <= 1'b0;
            PERIOD     <= '0;
            PERIOD_VLD <= 1'b0;
            STUCK      <= 1'b0;
            EDGE_CNT   <= 8'd0;
        end else begin
            r_s1       <= DIN;
            r_s2       <= r_s1;
            r_s3       <= r_s2;
            RISE       <= w_rise;
            FALL       <= w_fall;
            PERIOD_VLD <= 1'b0;

            r_pcnt <= w_rise ? '0 : w_period_nxt;
            r_icnt <= w_edge ? '0 : w_icnt_nxt;

            if (w_edge) begin
                EDGE_CNT <= EDGE_CNT + 8'd1;
            end

            if (w_timeout) begin
                r_state <= STK;
                STUCK   <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_rise) begin
                            r_state <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (w_rise) begin
                            PERIOD     <= w_period_nxt;
                            PERIOD_VLD <= 1'b1;
                        end
                    end
                    STK: begin
                        // Period is unknown after a stall: re-arm without a
                        // measurement on rise, drop the reference on fall.
                        if (w_rise) begin
                            r_state <= ARMED;
                            STUCK   <= 1'b0;
                        end else if (w_fall) begin
                            r_state <= IDLE;
                            STUCK   <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        STUCK   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_toggle_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_toggle_monitor
// Purpose  : Self-checking bench for toggle_monitor. Two instances (TIMEOUT 16
//            and 255) share DIN/RST_N; a time-based reference model predicts
//            every output after every clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_toggle_monitor;

    logic       CLK;
    logic       RST_N;
    logic       DIN;

    logic       a_level, a_rise, a_fall, a_edge, a_vld, a_stuck;
    logic [7:0] a_period, a_ecnt;
    logic       b_level, b_rise, b_fall, b_edge, b_vld, b_stuck;
    logic [7:0] b_period, b_ecnt;

    toggle_monitor #(.CNT_W(8), .TIMEOUT(16)) dut_a (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .DIN        (DIN),
        .LEVEL      (a_level),
        .RISE       (a_rise),
        .FALL       (a_fall),
        .EDGE       (a_edge),
        .PERIOD     (a_period),
        .PERIOD_VLD (a_vld),
        .STUCK      (a_stuck),
        .EDGE_CNT   (a_ecnt)
    );

    toggle_monitor #(.CNT_W(8), .TIMEOUT(255)) dut_b (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .DIN        (DIN),
        .LEVEL      (b_level),
        .RISE       (b_rise),
        .FALL       (b_fall),
        .EDGE       (b_edge),
        .PERIOD     (b_period),
        .PERIOD_VLD (b_vld),
        .STUCK      (b_stuck),
        .EDGE_CNT   (b_ecnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err    = 0;

    // ---------------- reference model (time based) ----------------
    int   cyc = 0;          // posedge counter
    logic hist [4];         // hist[k] = DIN sampled k posedges ago
    logic m_level;
    logic m_rise;
    logic m_fall;
    int   m_last_edge [2];
    int   m_last_rise [2];
    bit   m_ref       [2];
    bit   m_stuck     [2];
    bit   m_vld       [2];
    int   m_period    [2];
    int   m_ecnt      [2];

    function automatic int tmo(input int i);
        return (i == 0) ? 16 : 255;
    endfunction

    task automatic model_tick(input logic d, input logic rn);
        cyc++;
        if (!rn) begin
            for (int k = 0; k < 4; k++) hist[k] = 1'b0;
            m_level = 1'b0;
            m_rise  = 1'b0;
            m_fall  = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_last_edge[i] = cyc;
                m_last_rise[i] = cyc;
                m_ref[i]       = 1'b0;
                m_stuck[i]     = 1'b0;
                m_vld[i]       = 1'b0;
                m_period[i]    = 0;
                m_ecnt[i]      = 0;
            end
        end else begin
            hist[3] = hist[2];
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = d;
            m_level = hist[1];
            m_rise  = hist[2] & ~hist[3];
            m_fall  = ~hist[2] & hist[3];
            for (int i = 0; i < 2; i++) begin
                m_vld[i] = 1'b0;
                if (m_rise || m_fall) begin
                    if (m_rise) begin
                        if (m_ref[i] && !m_stuck[i]) begin
                            m_period[i] = (cyc - m_last_rise[i] > 255) ? 255 : cyc - m_last_rise[i];
                            m_vld[i]    = 1'b1;
                        end
                        m_ref[i]       = 1'b1;
                        m_last_rise[i] = cyc;
                    end else if (m_stuck[i]) begin
                        m_ref[i] = 1'b0;
                    end
                    m_stuck[i]     = 1'b0;
                    m_last_edge[i] = cyc;
                    m_ecnt[i]      = (m_ecnt[i] + 1) % 256;
                end else if (cyc - m_last_edge[i] >= tmo(i)) begin
                    m_stuck[i] = 1'b1;
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input int idx, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d] cyc=%0d observed=%0h expected=%0h", tag, idx, cyc, obs, exp);
        end
    endtask

    task automatic chk_inst(input int i, input logic lvl, input logic ri, input logic fa,
                            input logic ed, input logic [7:0] per, input logic vld,
                            input logic stk, input logic [7:0] ec);
        chk("level",  i, {7'd0, lvl}, {7'd0, m_level});
        chk("rise",   i, {7'd0, ri},  {7'd0, m_rise});
        chk("fall",   i, {7'd0, fa},  {7'd0, m_fall});
        chk("edge",   i, {7'd0, ed},  {7'd0, m_rise | m_fall});
        chk("period", i, per,         8'(m_period[i]));
        chk("pvld",   i, {7'd0, vld}, {7'd0, m_vld[i]});
        chk("stuck",  i, {7'd0, stk}, {7'd0, m_stuck[i]});
        chk("ecnt",   i, ec,          8'(m_ecnt[i]));
    endtask

    task automatic step(input logic d, input logic rn);
        DIN   = d;
        RST_N = rn;
        @(posedge CLK);
        model_tick(d, rn);
        #1;
        chk_inst(0, a_level, a_rise, a_fall, a_edge, a_period, a_vld, a_stuck, a_ecnt);
        chk_inst(1, b_level, b_rise, b_fall, b_edge, b_period, b_vld, b_stuck, b_ecnt);
    endtask

    task automatic hold(input logic d, input int n);
        for (int k = 0; k < n; k++) step(d, 1'b1);
    endtask

    logic dt;
    int   seg_len;

    initial begin
        DIN   = 1'b0;
        RST_N = 1'b0;
        for (int k = 0; k < 4; k++) hist[k] = 1'b0;

        // Reset for 2 cycles with DIN toggling, then idle low: STUCK at 16.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("rst_stuck", 0, {7'd0, a_stuck}, 8'd0);
        chk("rst_ecnt",  0, a_ecnt, 8'd0);
        hold(1'b0, 20);
        chk("idle_stuck", 0, {7'd0, a_stuck}, 8'd1);

        // Square wave 4 high / 4 low, 5 periods.
        step(1'b0, 1'b0);
        for (int p = 0; p < 5; p++) begin
            hold(1'b1, 4);
            hold(1'b0, 4);
        end
        hold(1'b0, 4);
        chk("sq_ecnt",   0, a_ecnt, 8'd10);
        chk("sq_period", 0, a_period, 8'd8);
        chk("sq_period", 1, b_period, 8'd8);

        // Held high -> STUCK on the TIMEOUT=16 instance only.
        hold(1'b1, 30);
        chk("held_stuck", 0, {7'd0, a_stuck}, 8'd1);
        chk("held_stuck", 1, {7'd0, b_stuck}, 8'd0);
        hold(1'b0, 5);
        hold(1'b1, 5);
        hold(1'b0, 5);
        hold(1'b1, 5);
        hold(1'b0, 3);
        chk("rearm_period", 0, a_period, 8'd10);

        // Saturation on the TIMEOUT=255 instance, then a 100-cycle period.
        hold(1'b1, 150);
        hold(1'b0, 150);
        hold(1'b1, 50);
        chk("sat_period", 1, b_period, 8'd255);
        hold(1'b0, 50);
        hold(1'b1, 5);
        chk("p100_period", 1, b_period, 8'd100);

        // Fastest toggle for 20 cycles.
        hold(1'b0, 4);
        dt = 1'b0;
        for (int k = 0; k < 20; k++) begin
            dt = ~dt;
            step(dt, 1'b1);
        end
        hold(dt, 4);

        // 260 edges from reset -> EDGE_CNT wraps to 4.
        step(1'b0, 1'b0);
        hold(1'b0, 2);
        dt = 1'b0;
        for (int k = 0; k < 260; k++) begin
            dt = ~dt;
            step(dt, 1'b1);
        end
        hold(dt, 4);
        chk("wrap_ecnt", 0, a_ecnt, 8'd4);
        chk("wrap_ecnt", 1, b_ecnt, 8'd4);

        // Mid-period reset, then first rise must not measure.
        hold(1'b1, 5);
        hold(1'b0, 3);
        step(1'b0, 1'b0);
        chk("mid_rst_period", 0, a_period, 8'd0);
        chk("mid_rst_ecnt",   1, b_ecnt, 8'd0);
        hold(1'b0, 3);
        hold(1'b1, 5);
        hold(1'b0, 5);
        hold(1'b1, 5);

        // Random segments with occasional resets.
        for (int s = 0; s < 40; s++) begin
            seg_len = $urandom_range(1, 40);
            dt      = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) step(dt, 1'b0);
            hold(dt, seg_len);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/toggle_monitor.md
# toggle_monitor

Receive-side companion to the flip-flop waveform generators in the bonus exercises: it samples an asynchronous toggling or held signal (such as a T-flip-flop output or a frozen/cleared register output) on CLK. It reports rising, falling and any-edge pulses, the measured rising-to-rising period, a running edge count, and a STUCK flag when the input stops toggling. It sits between a waveform source and the bench or display logic, classifying the source as toggling or held.

## Interface
- CNT_W, 8, width of PERIOD and of the internal period counter
- TIMEOUT, 16, consecutive no-edge cycles that declare STUCK (legal range 2..2^CNT_W-1)
- CLK  input  1  sole clock, all state updates on posedge
- RST_N  input  1  reset, synchronous, active-low
- DIN  input  1  monitored signal, asynchronous to CLK
- LEVEL  output  1  synchronized level of DIN
- RISE  output  1  one-cycle pulse per detected rising edge
- FALL  output  1  one-cycle pulse per detected falling edge
- EDGE  output  1  RISE | FALL, one-cycle pulse
- PERIOD  output  CNT_W  last measured rising-to-rising period in CLK cycles, saturating
- PERIOD_VLD  output  1  one-cycle pulse when PERIOD is updated
- STUCK  output  1  level, no edge seen for TIMEOUT cycles
- EDGE_CNT  output  8  count of detected edges, wraps 255 -> 0

## Operation
- Front end: two-flop synchronizer (s1, s2) followed by a history flop (s3). Detected rise = s2 & ~s3; detected fall = ~s2 & s3. LEVEL = s2.
- RISE, FALL, EDGE and PERIOD_VLD are registered. All outputs are registered except EDGE, which is RISE | FALL.
- Period counter pcnt (CNT_W bits): cleared on each detected rise. Otherwise it increments, saturating at 2^CNT_W-1.
- Idle counter icnt: cleared on any detected edge. Otherwise it increments, saturating at TIMEOUT.
- FSM states:
  - IDLE (reset state, no valid rise reference).
  - ARMED (a rise has been seen, pcnt is meaningful).
  - STK (STUCK = 1 exactly in this state).
- Transitions, evaluated in priority order each cycle:
  - Any state: icnt reaches TIMEOUT with no edge this cycle -> STK.
  - IDLE: rise -> ARMED, no PERIOD_VLD.
  - ARMED: rise -> stay ARMED. PERIOD <= min(pcnt+1, 2^CNT_W-1) and PERIOD_VLD pulses.
  - ARMED: fall -> stay ARMED.
  - STK: rise -> ARMED, no PERIOD_VLD, because the period is unknown after a stall.
  - STK: fall -> IDLE.
- EDGE_CNT increments by 1 on every detected edge in every state. It wraps modulo 256.
- PERIOD holds its last value until the next valid measurement. It is not cleared on entering STK.

## Timing
- Reset: when RST_N is low at a posedge, the following are all 0 from the next cycle: s1, s2, s3, LEVEL, RISE, FALL, EDGE, PERIOD, PERIOD_VLD, STUCK, EDGE_CNT, pcnt, icnt. The state is IDLE.
- Reset overrides all other activity, including mid-measurement or while in STK.
- Latency:
  - DIN first sampled high at posedge k gives LEVEL = 1 after posedge k+1.
  - RISE, EDGE and PERIOD_VLD are high for exactly the cycle following posedge k+2. FALL behaves the same for falling edges.
- For a clean square wave with rising edges P cycles apart (P ≥ 2), PERIOD = P on every PERIOD_VLD after the first rise.
- For DIN toggling every cycle (P = 2), RISE and FALL alternate every cycle. EDGE stays high continuously.
- STUCK rises exactly TIMEOUT cycles after the last EDGE pulse, or TIMEOUT cycles after reset release if no edge is seen.
- STUCK falls in the same cycle as the next RISE or FALL pulse.
- An edge arriving in the cycle icnt would reach TIMEOUT takes priority: STK is not entered.
- DIN pulses shorter than one CLK period may be missed. This is not an error.

## Test plan
- Reset: hold RST_N = 0 for 2 cycles with DIN toggling -> all outputs 0 on the first cycle after release. STUCK stays 0 until TIMEOUT cycles pass without an edge.
- Square wave with 4 cycles high and 4 low, 5 periods -> first rise gives no PERIOD_VLD. Then 4 PERIOD_VLD pulses with PERIOD = 8, spaced 8 cycles apart. EDGE_CNT = 10. STUCK = 0 throughout.
- Held input, TIMEOUT = 16: one rise, then DIN = 1 held -> STUCK = 1 exactly 16 cycles after the RISE pulse.
  - A later fall -> FALL and STUCK = 0 in the same cycle; state IDLE.
  - The next rise -> no PERIOD_VLD.
  - The following rise -> PERIOD_VLD with the correct period.
- Saturation, CNT_W = 8, TIMEOUT = 255: rising edges 300 cycles apart with a fall midway -> PERIOD = 255 and PERIOD_VLD pulses. A period of 100 afterwards -> PERIOD = 100.
- Fastest toggle: DIN inverted every posedge for 20 cycles -> EDGE high continuously and RISE/FALL alternate. PERIOD = 2 on each PERIOD_VLD. EDGE_CNT counts 20.
- Wrap and mid-operation reset:
  - 260 edges -> EDGE_CNT = 4.
  - Pull RST_N low for 1 cycle mid-period -> all outputs 0 and state IDLE.
  - The first rise after reset gives no PERIOD_VLD.
